// File: rtl/expansion_rom_arbiter.sv
// Arbiter for the shared $C800-$CFFF expansion-ROM window: tracks the claiming slot,
// decodes the one-hot per-slot ROM enable, and muxes card read data by slot priority.
module expansion_rom_arbiter #(
  parameter int unsigned CONFLICT_W = 16,
  parameter logic [7:0]  ROM_SLOTS  = 8'hFE
) (
  input  logic                  clk_logic_i,
  input  logic                  system_reset_i,
  input  logic                  bus_strobe_i,
  input  logic [15:0]           addr_i,
  input  logic                  intcxrom_i,
  input  logic                  slotc3rom_i,
  input  logic [7:0]            rom_capable_i,
  input  logic [7:0]            card_rd_en_i,
  input  logic [63:0]           card_data_i,
  output logic [2:0]            rom_owner_o,
  output logic                  rom_owned_o,
  output logic [7:0]            rom_en_o,
  output logic [7:0]            data_o,
  output logic                  rd_en_o,
  output logic                  conflict_o,
  output logic [CONFLICT_W-1:0] conflict_count_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t                state_q;
  logic [2:0]            owner_q;
  logic [7:0]            data_q;
  logic [7:0]            data_d;
  logic                  rd_en_q;
  logic                  conflict_q;
  logic                  conflict_d;
  logic [CONFLICT_W-1:0] count_q;
  logic [CONFLICT_W-1:0] count_d;

  // Address decode shared by the FSM and the enable logic.
  logic       in_cn_page;
  logic       in_window;
  logic       is_cfff;
  logic [2:0] claim_slot;
  logic       claim_ok;
  logic       release_ok;

  assign in_cn_page = (addr_i[15:11] == 5'b11000);
  assign in_window  = (addr_i[15:11] == 5'b11001);
  assign is_cfff    = (addr_i == 16'hCFFF);
  assign claim_slot = addr_i[10:8];

  // Slot 3 ROM is only reachable when the $C300 page is mapped to the card.
  always_comb begin
    claim_ok = 1'b0;
    if (in_cn_page && (claim_slot != 3'd0) && !intcxrom_i) begin
      claim_ok = ROM_SLOTS[claim_slot] && rom_capable_i[claim_slot];
      if (claim_slot == 3'd3) begin
        claim_ok = claim_ok && slotc3rom_i;
      end
    end
  end

  assign release_ok = is_cfff && !intcxrom_i;

  always_ff @(posedge clk_logic_i or posedge system_reset_i) begin
    if (system_reset_i) begin
      state_q <= ST_IDLE;
      owner_q <= 3'd0;
    end else if (bus_strobe_i) begin
      if (claim_ok) begin
        state_q <= ST_OWNED;
        owner_q <= claim_slot;
      end else if (release_ok) begin
        state_q <= ST_IDLE;
        owner_q <= 3'd0;
      end
    end
  end

  assign rom_owner_o = owner_q;
  assign rom_owned_o = (state_q == ST_OWNED);

  // Ownership survives intcxrom_i; only the enable is suppressed while it is high.
  assign rom_en_o[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_rom_en
      assign rom_en_o[gi] = (state_q == ST_OWNED) && (owner_q == gi[2:0]) &&
                            !intcxrom_i && in_window && !is_cfff;
    end
  endgenerate

  // Lowest-numbered requester wins: scan downward so the last hit is the lowest slot.
  logic [2:0] winner;
  always_comb begin
    winner = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (card_rd_en_i[i]) begin
        winner = i[2:0];
      end
    end
  end

  logic [3:0] req_count;
  always_comb begin
    req_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      req_count = req_count + {3'd0, card_rd_en_i[i]};
    end
  end

  always_comb begin
    data_d = data_q;
    if (|card_rd_en_i) begin
      data_d = card_data_i[winner*8 +: 8];
    end
  end

  always_comb begin
    conflict_d = bus_strobe_i && (req_count >= 4'd2);
    count_d    = count_q;
    if (conflict_d && !(&count_q)) begin
      count_d = count_q + {{(CONFLICT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_logic_i or posedge system_reset_i) begin
    if (system_reset_i) begin
      data_q     <= 8'd0;
      rd_en_q    <= 1'b0;
      conflict_q <= 1'b0;
      count_q    <= '0;
    end else begin
      data_q     <= data_d;
      rd_en_q    <= |card_rd_en_i;
      conflict_q <= conflict_d;
      count_q    <= count_d;
    end
  end

  assign data_o           = data_q;
  assign rd_en_o          = rd_en_q;
  assign conflict_o       = conflict_q;
  assign conflict_count_o = count_q;

endmodule

// File: tb/tb_expansion_rom_arbiter.sv
// Scoreboard bench for expansion_rom_arbiter: expectations are queued with each stimulus
// step and compared against the DUT once the step's outputs are due.
module tb_expansion_rom_arbiter;

  localparam int CW = 4;

  logic          clk_logic_i = 1'b0;
  logic          system_reset_i = 1'b1;
  logic          bus_strobe_i = 1'b0;
  logic [15:0]   addr_i = 16'h0000;
  logic          intcxrom_i = 1'b0;
  logic          slotc3rom_i = 1'b0;
  logic [7:0]    rom_capable_i = 8'h00;
  logic [7:0]    card_rd_en_i = 8'h00;
  logic [63:0]   card_data_i = 64'h0;
  logic [2:0]    rom_owner_o;
  logic          rom_owned_o;
  logic [7:0]    rom_en_o;
  logic [7:0]    data_o;
  logic          rd_en_o;
  logic          conflict_o;
  logic [CW-1:0] conflict_count_o;

  expansion_rom_arbiter #(.CONFLICT_W(CW), .ROM_SLOTS(8'hFE)) dut (
    .clk_logic_i      (clk_logic_i),
    .system_reset_i   (system_reset_i),
    .bus_strobe_i     (bus_strobe_i),
    .addr_i           (addr_i),
    .intcxrom_i       (intcxrom_i),
    .slotc3rom_i      (slotc3rom_i),
    .rom_capable_i    (rom_capable_i),
    .card_rd_en_i     (card_rd_en_i),
    .card_data_i      (card_data_i),
    .rom_owner_o      (rom_owner_o),
    .rom_owned_o      (rom_owned_o),
    .rom_en_o         (rom_en_o),
    .data_o           (data_o),
    .rd_en_o          (rd_en_o),
    .conflict_o       (conflict_o),
    .conflict_count_o (conflict_count_o)
  );

  always #5 clk_logic_i = ~clk_logic_i;

  localparam int O_OWNER = 0, O_OWNED = 1, O_EN = 2, O_DATA = 3,
                 O_RDEN = 4, O_CONF = 5, O_CNT = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [15:0] observe(int sel);
    case (sel)
      O_OWNER: return {13'd0, rom_owner_o};
      O_OWNED: return {15'd0, rom_owned_o};
      O_EN:    return {8'd0, rom_en_o};
      O_DATA:  return {8'd0, data_o};
      O_RDEN:  return {15'd0, rd_en_o};
      O_CONF:  return {15'd0, conflict_o};
      default: return {{(16-CW){1'b0}}, conflict_count_o};
    endcase
  endfunction

  task automatic check_eq(string tag, logic [15:0] obs, logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic expect_out(string tag, int sel, logic [15:0] v);
    sb_q.push_back('{tag: tag, sel: sel, exp: v});
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_logic_i);
    #1;
  endtask

  task automatic strobe(logic [15:0] a);
    addr_i = a;
    bus_strobe_i = 1'b1;
    tick();
    bus_strobe_i = 1'b0;
  endtask

  task automatic look(logic [15:0] a);
    addr_i = a;
    #1;
  endtask

  initial begin
    // Reset state
    #1;
    expect_out("rst_owner", O_OWNER, 0);
    expect_out("rst_owned", O_OWNED, 0);
    expect_out("rst_en",    O_EN,    0);
    expect_out("rst_data",  O_DATA,  0);
    expect_out("rst_rden",  O_RDEN,  0);
    expect_out("rst_conf",  O_CONF,  0);
    expect_out("rst_cnt",   O_CNT,   0);
    drain();
    tick();
    tick();
    system_reset_i = 1'b0;
    tick();

    // T1 claim by slot 2, window enable, $CFFF masks enable
    rom_capable_i = 8'h04;
    expect_out("t1_owner", O_OWNER, 2);
    expect_out("t1_owned", O_OWNED, 1);
    strobe(16'hC200);
    drain();
    expect_out("t1_en_c9ab", O_EN, 16'h04);
    look(16'hC9AB);
    drain();
    expect_out("t1_en_cfff", O_EN, 0);
    look(16'hCFFF);
    drain();

    // T2 release
    expect_out("t2_owner", O_OWNER, 0);
    expect_out("t2_owned", O_OWNED, 0);
    strobe(16'hCFFF);
    drain();
    expect_out("t2_en_c800", O_EN, 0);
    look(16'hC800);
    drain();

    // T3 steal by slot 5, refused claim by non-capable slot 6
    strobe(16'hC200);
    rom_capable_i = 8'h24;
    expect_out("t3_owner5", O_OWNER, 5);
    strobe(16'hC500);
    drain();
    expect_out("t3_en_c800", O_EN, 16'h20);
    look(16'hC800);
    drain();
    expect_out("t3_owner_keep", O_OWNER, 5);
    strobe(16'hC600);
    drain();
    strobe(16'hCFFF);

    // T4 intcxrom blocks claim and release, masks enable, keeps owner
    rom_capable_i = 8'h04;
    intcxrom_i = 1'b1;
    expect_out("t4_noclaim", O_OWNED, 0);
    strobe(16'hC200);
    drain();
    intcxrom_i = 1'b0;
    strobe(16'hC200);
    intcxrom_i = 1'b1;
    expect_out("t4_en_masked", O_EN, 0);
    expect_out("t4_owner_kept", O_OWNER, 2);
    look(16'hC800);
    drain();
    expect_out("t4_norelease", O_OWNER, 2);
    strobe(16'hCFFF);
    drain();
    intcxrom_i = 1'b0;
    expect_out("t4_en_back", O_EN, 16'h04);
    look(16'hC800);
    drain();
    strobe(16'hCFFF);

    // T5 slot 3 gated by slotc3rom_i
    rom_capable_i = 8'h08;
    slotc3rom_i = 1'b0;
    expect_out("t5_idle", O_OWNED, 0);
    strobe(16'hC300);
    drain();
    slotc3rom_i = 1'b1;
    expect_out("t5_owner3", O_OWNER, 3);
    strobe(16'hC300);
    drain();

    // T6 read priority and conflict
    card_data_i = 64'h0;
    card_data_i[23:16] = 8'hA5;
    card_data_i[47:40] = 8'h3C;
    card_rd_en_i = 8'h24;
    expect_out("t6_data",  O_DATA, 16'hA5);
    expect_out("t6_rden",  O_RDEN, 1);
    expect_out("t6_conf",  O_CONF, 1);
    expect_out("t6_cnt1",  O_CNT,  1);
    strobe(16'h0000);
    drain();
    expect_out("t6_conf_pulse_end", O_CONF, 0);
    expect_out("t6_cnt_nostrobe",   O_CNT,  1);
    tick();
    drain();
    card_rd_en_i = 8'h00;
    expect_out("t6_rden_idle", O_RDEN, 0);
    expect_out("t6_data_hold", O_DATA, 16'hA5);
    tick();
    drain();
    card_rd_en_i = 8'h20;
    expect_out("t6_data_slot5", O_DATA, 16'h3C);
    expect_out("t6_single_noconf", O_CONF, 0);
    strobe(16'h0000);
    drain();

    // Saturation of the narrow counter
    card_rd_en_i = 8'h24;
    for (int i = 0; i < 16; i++) strobe(16'h0000);
    expect_out("t6_cnt_sat", O_CNT, 16'h000F);
    expect_out("t6_conf_at_sat", O_CONF, 1);
    strobe(16'h0000);
    drain();

    // Asynchronous reset mid bus cycle with a claim and a conflict pending
    rom_capable_i = 8'h04;
    addr_i = 16'hC800;
    bus_strobe_i = 1'b1;
    #2;
    system_reset_i = 1'b1;
    #1;
    expect_out("rr_owner", O_OWNER, 0);
    expect_out("rr_owned", O_OWNED, 0);
    expect_out("rr_en",    O_EN,    0);
    expect_out("rr_data",  O_DATA,  0);
    expect_out("rr_rden",  O_RDEN,  0);
    expect_out("rr_conf",  O_CONF,  0);
    expect_out("rr_cnt",   O_CNT,   0);
    drain();
    tick();
    tick();
    system_reset_i = 1'b0;
    bus_strobe_i = 1'b0;
    card_rd_en_i = 8'h00;
    expect_out("rr_after_owned", O_OWNED, 0);
    expect_out("rr_after_conf",  O_CONF,  0);
    expect_out("rr_after_cnt",   O_CNT,   0);
    tick();
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
